// File: rtl/serial_mag_comp_if.sv
// Start/done handshake bundle for the serial magnitude comparator.
// Master issues operands and start; slave returns busy, done and result.
interface serial_mag_comp_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             signed_mode;
    logic             gt_in;
    logic             lt_in;
    logic             busy;
    logic             done;
    logic             gt;
    logic             eq;
    logic             lt;

    modport master (
        output start, A, B, signed_mode, gt_in, lt_in,
        input  busy, done, gt, eq, lt
    );

    modport slave (
        input  start, A, B, signed_mode, gt_in, lt_in,
        output busy, done, gt, eq, lt
    );
endinterface

// File: rtl/serial_mag_comp.sv
// Multi-cycle magnitude comparator: one CHUNK-bit digit per clock, MSB first.
// Supports two's-complement mode, early exit and cascade tie-breaking.
module serial_mag_comp #(
    parameter int WIDTH      = 16,
    parameter int CHUNK      = 4,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    serial_mag_comp_if.slave      bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IW-1:0] TOP = IW'(NCHUNK - 1);

    generate
        if (WIDTH % CHUNK != 0) begin : g_bad_width
            $error("serial_mag_comp: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic {
        IDLE,
        COMPARE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sm_q, sm_d;
    logic             gin_q, gin_d;
    logic             lin_q, lin_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             found_q, found_d;
    logic             rgt_q, rgt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             gt_q, gt_d;
    logic             eq_q, eq_d;
    logic             lt_q, lt_d;

    logic [CHUNK-1:0] da;
    logic [CHUNK-1:0] db;
    logic             dgt;
    logic             dlt;
    logic             res_diff;
    logic             res_gt;
    logic             last;

    // Current digit; in signed mode flipping the sign bit of the top digit
    // turns two's-complement order into unsigned order.
    always_comb begin
        da = '0;
        db = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (idx_q == IW'(i)) begin
                da = a_q[i*CHUNK +: CHUNK];
                db = b_q[i*CHUNK +: CHUNK];
            end
        end
        if (sm_q && (idx_q == TOP)) begin
            da[CHUNK-1] = ~da[CHUNK-1];
            db[CHUNK-1] = ~db[CHUNK-1];
        end
    end

    assign dgt      = (da > db);
    assign dlt      = (da < db);
    assign res_diff = found_q | dgt | dlt;
    assign res_gt   = found_q ? rgt_q : dgt;
    assign last     = (idx_q == '0) ||
                      (EARLY_EXIT && !found_q && (dgt || dlt));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sm_d    = sm_q;
        gin_d   = gin_q;
        lin_d   = lin_q;
        idx_d   = idx_q;
        found_d = found_q;
        rgt_d   = rgt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        gt_d    = gt_q;
        eq_d    = eq_q;
        lt_d    = lt_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.A;
                    b_d     = bus.B;
                    sm_d    = bus.signed_mode;
                    gin_d   = bus.gt_in;
                    lin_d   = bus.lt_in;
                    idx_d   = TOP;
                    found_d = 1'b0;
                    rgt_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                if (last) begin
                    if (res_diff) begin
                        gt_d = res_gt;
                        eq_d = 1'b0;
                        lt_d = ~res_gt;
                    end else begin
                        gt_d = gin_q;
                        lt_d = ~gin_q & lin_q;
                        eq_d = ~gin_q & ~lin_q;
                    end
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    found_d = res_diff;
                    rgt_d   = res_gt;
                    idx_d   = idx_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sm_q    <= 1'b0;
            gin_q   <= 1'b0;
            lin_q   <= 1'b0;
            idx_q   <= '0;
            found_q <= 1'b0;
            rgt_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sm_q    <= sm_d;
            gin_q   <= gin_d;
            lin_q   <= lin_d;
            idx_q   <= idx_d;
            found_q <= found_d;
            rgt_q   <= rgt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            gt_q    <= gt_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.gt   = gt_q;
    assign bus.eq   = eq_q;
    assign bus.lt   = lt_q;
endmodule

// File: tb/tb_serial_mag_comp.sv
// Directed bench for serial_mag_comp: early-exit and constant-latency
// instances driven in parallel, results as {gt,eq,lt}.
module tb_serial_mag_comp;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    serial_mag_comp_if #(.WIDTH(16)) if1 ();
    serial_mag_comp_if #(.WIDTH(16)) if0 ();

    serial_mag_comp #(
        .WIDTH(16), .CHUNK(4), .EARLY_EXIT(1'b1)
    ) u_ee1 (
        .clk(clk), .rst(rst), .bus(if1.slave)
    );

    serial_mag_comp #(
        .WIDTH(16), .CHUNK(4), .EARLY_EXIT(1'b0)
    ) u_ee0 (
        .clk(clk), .rst(rst), .bus(if0.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_in(input logic [15:0] a, input logic [15:0] b,
                          input logic sm, input logic gi,
                          input logic li, input logic st);
        if1.A = a; if1.B = b; if1.signed_mode = sm;
        if1.gt_in = gi; if1.lt_in = li; if1.start = st;
        if0.A = a; if0.B = b; if0.signed_mode = sm;
        if0.gt_in = gi; if0.lt_in = li; if0.start = st;
    endtask

    task automatic run_cmp(input logic [15:0] a, input logic [15:0] b,
                           input logic sm, input logic gi, input logic li,
                           output int l1, output logic [2:0] r1,
                           output int l0, output logic [2:0] r0,
                           output bit bok);
        set_in(a, b, sm, gi, li, 1'b1);
        @(posedge clk); #1;
        if1.start = 1'b0; if0.start = 1'b0;
        l1 = -1; l0 = -1; r1 = 'x; r0 = 'x;
        bok = (if1.busy === 1'b1) && (if0.busy === 1'b1);
        for (int n = 1; n <= 20 && (l1 < 0 || l0 < 0); n++) begin
            @(posedge clk); #1;
            if (l1 < 0) begin
                if (if1.done === 1'b1) begin
                    l1 = n; r1 = {if1.gt, if1.eq, if1.lt};
                end else if (if1.busy !== 1'b1) bok = 0;
            end
            if (l0 < 0) begin
                if (if0.done === 1'b1) begin
                    l0 = n; r0 = {if0.gt, if0.eq, if0.lt};
                end else if (if0.busy !== 1'b1) bok = 0;
            end
        end
    endtask

    task automatic test_reset();
        logic [4:0] o1, o0;
        set_in(16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        o1 = {if1.busy, if1.done, if1.gt, if1.eq, if1.lt};
        o0 = {if0.busy, if0.done, if0.gt, if0.eq, if0.lt};
        checks++;
        if (o1 !== 5'b0) begin
            errors++;
            $display("FAIL reset_ee1 got %b want 00000", o1);
        end
        checks++;
        if (o0 !== 5'b0) begin
            errors++;
            $display("FAIL reset_ee0 got %b want 00000", o0);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_equal();
        int l1, l0; logic [2:0] r1, r0; bit bok;
        run_cmp(16'h1234, 16'h1234, 1'b0, 1'b0, 1'b0, l1, r1, l0, r0, bok);
        checks++;
        if (l1 !== 4 || r1 !== 3'b010) begin
            errors++;
            $display("FAIL equal_ee1 got lat %0d res %b want lat 4 res 010", l1, r1);
        end
        checks++;
        if (l0 !== 4 || r0 !== 3'b010) begin
            errors++;
            $display("FAIL equal_ee0 got lat %0d res %b want lat 4 res 010", l0, r0);
        end
        checks++;
        if (bok !== 1'b1) begin
            errors++;
            $display("FAIL equal_busy got %b want 1", bok);
        end
    endtask

    task automatic test_msb();
        int l1, l0; logic [2:0] r1, r0; bit bok;
        logic [3:0] h;
        run_cmp(16'h8000, 16'h7FFF, 1'b0, 1'b0, 1'b0, l1, r1, l0, r0, bok);
        checks++;
        if (l1 !== 1 || r1 !== 3'b100) begin
            errors++;
            $display("FAIL msb_uns_ee1 got lat %0d res %b want lat 1 res 100", l1, r1);
        end
        checks++;
        if (l0 !== 4 || r0 !== 3'b100) begin
            errors++;
            $display("FAIL msb_uns_ee0 got lat %0d res %b want lat 4 res 100", l0, r0);
        end
        repeat (2) @(posedge clk);
        #1;
        h = {if1.done, if1.gt, if1.eq, if1.lt};
        checks++;
        if (h !== 4'b0100) begin
            errors++;
            $display("FAIL msb_hold got %b want 0100", h);
        end
        run_cmp(16'h8000, 16'h7FFF, 1'b1, 1'b0, 1'b0, l1, r1, l0, r0, bok);
        checks++;
        if (l1 !== 1 || r1 !== 3'b001) begin
            errors++;
            $display("FAIL msb_sgn_ee1 got lat %0d res %b want lat 1 res 001", l1, r1);
        end
        checks++;
        if (l0 !== 4 || r0 !== 3'b001) begin
            errors++;
            $display("FAIL msb_sgn_ee0 got lat %0d res %b want lat 4 res 001", l0, r0);
        end
    endtask

    task automatic test_late_digit();
        int l1, l0; logic [2:0] r1, r0; bit bok;
        run_cmp(16'h1235, 16'h1234, 1'b0, 1'b0, 1'b0, l1, r1, l0, r0, bok);
        checks++;
        if (l1 !== 4 || r1 !== 3'b100 || r0 !== 3'b100) begin
            errors++;
            $display("FAIL late_gt got lat %0d res %b/%b want lat 4 res 100", l1, r1, r0);
        end
        run_cmp(16'hFFFE, 16'hFFFF, 1'b1, 1'b0, 1'b0, l1, r1, l0, r0, bok);
        checks++;
        if (l1 !== 4 || r1 !== 3'b001 || r0 !== 3'b001) begin
            errors++;
            $display("FAIL late_sgn_lt got lat %0d res %b/%b want lat 4 res 001", l1, r1, r0);
        end
    endtask

    task automatic test_cascade();
        int l1, l0; logic [2:0] r1, r0; bit bok;
        run_cmp(16'h00AA, 16'h00AA, 1'b0, 1'b0, 1'b1, l1, r1, l0, r0, bok);
        checks++;
        if (r1 !== 3'b001 || r0 !== 3'b001) begin
            errors++;
            $display("FAIL cascade_lt got %b/%b want 001", r1, r0);
        end
        run_cmp(16'h00AA, 16'h00AA, 1'b0, 1'b1, 1'b1, l1, r1, l0, r0, bok);
        checks++;
        if (r1 !== 3'b100 || r0 !== 3'b100) begin
            errors++;
            $display("FAIL cascade_gt got %b/%b want 100", r1, r0);
        end
        run_cmp(16'h00AA, 16'h00AA, 1'b0, 1'b0, 1'b0, l1, r1, l0, r0, bok);
        checks++;
        if (r1 !== 3'b010 || r0 !== 3'b010 || l1 !== 4) begin
            errors++;
            $display("FAIL cascade_eq got %b/%b lat %0d want 010 lat 4", r1, r0, l1);
        end
    endtask

    task automatic test_ignore_start();
        int l1; logic [2:0] r1; int extra;
        set_in(16'h1234, 16'h1235, 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        set_in(16'h1234, 16'h1235, 1'b0, 1'b0, 1'b0, 1'b0);
        l1 = -1; r1 = 'x; extra = 0;
        for (int n = 1; n <= 10; n++) begin
            if (n == 2) set_in(16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1);
            @(posedge clk); #1;
            if (n == 2) set_in(16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
            if (if1.done === 1'b1) begin
                if (l1 < 0) begin
                    l1 = n; r1 = {if1.gt, if1.eq, if1.lt};
                end else extra++;
            end
        end
        checks++;
        if (l1 !== 4 || r1 !== 3'b001) begin
            errors++;
            $display("FAIL ignore_start got lat %0d res %b want lat 4 res 001", l1, r1);
        end
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL ignore_extra_done got %0d want 0", extra);
        end
    endtask

    task automatic test_mid_reset();
        logic [3:0] o; int dn;
        set_in(16'h1234, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        if1.start = 1'b0; if0.start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        o = {if1.busy, if1.gt, if1.eq, if1.lt};
        checks++;
        if (o !== 4'b0 || if0.busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got %b busy0 %b want 0000 0", o, if0.busy);
        end
        dn = 0;
        for (int n = 0; n < 6; n++) begin
            if (if1.done === 1'b1 || if0.done === 1'b1) dn++;
            @(posedge clk); #1;
        end
        checks++;
        if (dn !== 0) begin
            errors++;
            $display("FAIL mid_reset_done got %0d want 0", dn);
        end
    endtask

    task automatic test_back_to_back();
        int l1; logic [2:0] r1; bit held;
        set_in(16'h8000, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        set_in(16'h8000, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        checks++;
        if (if1.done !== 1'b1 || {if1.gt, if1.eq, if1.lt} !== 3'b100) begin
            errors++;
            $display("FAIL b2b_first got done %b res %b want 1 100",
                     if1.done, {if1.gt, if1.eq, if1.lt});
        end
        set_in(16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        set_in(16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);
        held = (if1.busy === 1'b1) && (if1.done === 1'b0);
        l1 = -1; r1 = 'x;
        for (int n = 1; n <= 10 && l1 < 0; n++) begin
            if ({if1.gt, if1.eq, if1.lt} !== 3'b100) held = 0;
            @(posedge clk); #1;
            if (if1.done === 1'b1) begin
                l1 = n; r1 = {if1.gt, if1.eq, if1.lt};
            end
        end
        checks++;
        if (held !== 1'b1) begin
            errors++;
            $display("FAIL b2b_hold got %b want 1", held);
        end
        checks++;
        if (l1 !== 4 || r1 !== 3'b001) begin
            errors++;
            $display("FAIL b2b_second got lat %0d res %b want lat 4 res 001", l1, r1);
        end
        repeat (6) @(posedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        set_in(16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_equal();
        test_msb();
        test_late_digit();
        test_cascade();
        test_ignore_start();
        test_mid_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_mag_comp.md
Name: serial_mag_comp

Overview:
- Parametrised, multi-cycle magnitude comparator. Successor to the 4-bit cascadable comparator.
- Compares two WIDTH-bit operands one CHUNK-bit digit per clock, most significant digit first.
- Supports unsigned and two's-complement modes, optional early exit, and cascade inputs that resolve fully-equal operands.
- Sits in the datapath where wide operands are compared under a start/done handshake instead of a wide combinational tree.

Parameters:
WIDTH, 16, operand width in bits; must be a multiple of CHUNK.
CHUNK, 4, bits compared per cycle; NCHUNK = WIDTH/CHUNK.
EARLY_EXIT, 1, 1 = finish at the first differing digit; 0 = always run NCHUNK digit cycles (constant latency).

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  synchronous reset, active-high.
start  in  1  request a comparison; sampled only when busy=0.
A  in  WIDTH  operand A; latched on an accepted start.
B  in  WIDTH  operand B; latched on an accepted start.
signed_mode  in  1  1 = two's-complement compare; latched on start.
gt_in  in  1  cascade from the lower-significance stage; latched on start.
lt_in  in  1  cascade from the lower-significance stage; latched on start.
busy  out  1  high while a comparison is in progress.
done  out  1  one-cycle pulse when a result is valid.
gt  out  1  A > B.
eq  out  1  A == B.
lt  out  1  A < B.

Behaviour:
- Reset (rst=1 at a clock edge), all cycles including mid-operation:
  - State returns to IDLE.
  - busy=0, done=0, gt=0, eq=0, lt=0.
  - Latched operands and the digit index are cleared.
  - An in-flight comparison is discarded; no done is produced for it.
- States: IDLE, COMPARE.
- IDLE:
  - On start=1 at an edge: latch A, B, signed_mode, gt_in, lt_in.
  - Set idx=NCHUNK-1, set busy=1, go to COMPARE.
- COMPARE, at each edge, for digit idx:
  - Compare the A and B bits [idx*CHUNK +: CHUNK] as unsigned values.
  - Signed mode: on the top digit (idx=NCHUNK-1) only, invert the MSB of both digits before comparing.
  - First differing digit: record gt or lt.
  - EARLY_EXIT=1: that edge is the final edge.
  - EARLY_EXIT=0: keep stepping, but the recorded result is frozen and later digits do not change it.
  - Otherwise decrement idx.
- idx=0 with all digits equal, cascade priority:
  - gt_in=1 -> gt.
  - else lt_in=1 -> lt.
  - else eq.
- Final edge:
  - Load the gt/eq/lt registers (exactly one high).
  - done=1 for the next cycle only.
  - busy=0, state returns to IDLE.
- Latency: k cycles from the start-accept edge to done high.
  - k = 1-based count of digits examined, MSB first.
  - EARLY_EXIT=0: k = NCHUNK always.
- Result outputs hold their value from one done until the next done, or until reset.
- start while busy=1 is ignored. No queueing, no effect on the current comparison.
- Operand and mode inputs are don't-care after the start edge.
- start during the done cycle: state is already IDLE, so it is accepted (back-to-back operation). Outputs keep the previous result until the new done.
- start and rst both high at the same edge: reset wins.
- Synthesis-time check: WIDTH mod CHUNK != 0 is an error.
- CHUNK=WIDTH is legal: single-cycle compare, latency 1.

Test Plan:
(WIDTH=16, CHUNK=4, EARLY_EXIT=1 unless noted.)
1. A=0x1234, B=0x1234, unsigned, gt_in=lt_in=0 -> done 4 cycles after start; eq=1, gt=lt=0; busy high for those 4 cycles.
2. A=0x8000, B=0x7FFF:
   - unsigned -> gt=1, done after 1 cycle.
   - repeat with signed_mode=1 -> lt=1, done after 1 cycle.
   - repeat both with EARLY_EXIT=0 -> same results, done after 4 cycles.
3. A=0x1235, B=0x1234 -> gt=1 after 4 cycles. A=0xFFFE, B=0xFFFF in signed mode (-2 vs -1) -> lt=1 after 4 cycles.
4. A=B=0x00AA:
   - lt_in=1 -> lt=1.
   - gt_in=1, lt_in=1 -> gt=1.
   - cascade both 0 -> eq=1.
5. Start a 4-cycle compare and pulse start again in cycle 2 -> ignored; the original result is delivered.
   Start again and assert rst in cycle 2 -> busy=0, gt=eq=lt=0, no done pulse.
6. Assert start in the done cycle with new operands (0x0001 vs 0x0002) -> accepted; previous outputs held; lt=1 at the new done.
